// File: rtl/iicmb_wb_sequencer.sv
// Wishbone master that walks the IICMB register sequence for one single-byte I2C
// transfer, pacing each command on irq and turning the CMDR status into a response.
module iicmb_wb_sequencer #(
    parameter int unsigned WB_ADDR_WIDTH  = 2,
    parameter int unsigned WB_DATA_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rnw,
    input  logic [7:0]               req_bus,
    input  logic [6:0]               req_addr,
    input  logic [7:0]               req_data,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_status,
    output logic [7:0]               rsp_data,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WB_ADDR_WIDTH-1:0] AdrCsr  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] AdrDpr  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] AdrCmdr = WB_ADDR_WIDTH'(2);

    localparam logic [1:0] RspOk  = 2'd0;
    localparam logic [1:0] RspNak = 2'd1;
    localparam logic [1:0] RspAl  = 2'd2;
    localparam logic [1:0] RspErr = 2'd3;

    typedef enum logic [3:0] {
        StIdle, StEn, StBusDpr, StBusCmd, StStartCmd, StAddrDpr, StAddrCmd, StWrDpr,
        StWrCmd, StRdCmd, StRdDpr, StStopCmd, StWait, StIrqRd, StResp
    } state_e;

    typedef enum logic [2:0] {PhBus, PhStart, PhAddr, PhWr, PhRd, PhStop} phase_e;

    state_e                   state_q, state_d;
    phase_e                   phase_q, phase_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     core_en_q, core_en_d;
    logic                     rnw_q, rnw_d;
    logic [7:0]               bus_q, bus_d;
    logic [6:0]               addr_q, addr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic [7:0]               rdata_q, rdata_d;
    logic [1:0]               status_q, status_d;
    logic                     ready_q, ready_d;
    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

    logic                     acc_req;
    logic                     acc_we;
    logic [WB_ADDR_WIDTH-1:0] acc_adr;
    logic [WB_DATA_WIDTH-1:0] acc_dat;
    logic                     acc_done;
    logic                     st_don, st_nak, st_al, st_err;

    assign acc_done = cyc_q & ack_i;
    assign st_don   = dat_i[7];
    assign st_nak   = dat_i[6];
    assign st_al    = dat_i[5];
    assign st_err   = dat_i[4];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            phase_q   <= PhBus;
            cnt_q     <= '0;
            core_en_q <= 1'b0;
            rnw_q     <= 1'b0;
            bus_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            status_q  <= RspOk;
            ready_q   <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            core_en_q <= core_en_d;
            rnw_q     <= rnw_d;
            bus_q     <= bus_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
            ready_q   <= ready_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
        end
    end

    // Register access requested by the current state.
    always_comb begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        acc_adr = AdrCmdr;
        acc_dat = '0;
        unique case (state_q)
            StEn:       begin acc_adr = AdrCsr; acc_dat = WB_DATA_WIDTH'(8'hC0); end
            StBusDpr:   begin acc_adr = AdrDpr; acc_dat = WB_DATA_WIDTH'(bus_q); end
            StBusCmd:   acc_dat = WB_DATA_WIDTH'(8'h06);
            StStartCmd: acc_dat = WB_DATA_WIDTH'(8'h04);
            StAddrDpr:  begin acc_adr = AdrDpr; acc_dat = WB_DATA_WIDTH'({addr_q, rnw_q}); end
            StAddrCmd:  acc_dat = WB_DATA_WIDTH'(8'h01);
            StWrDpr:    begin acc_adr = AdrDpr; acc_dat = WB_DATA_WIDTH'(wdata_q); end
            StWrCmd:    acc_dat = WB_DATA_WIDTH'(8'h01);
            StRdCmd:    acc_dat = WB_DATA_WIDTH'(8'h03);
            StRdDpr:    begin acc_adr = AdrDpr; acc_we = 1'b0; end
            StStopCmd:  acc_dat = WB_DATA_WIDTH'(8'h05);
            StIrqRd:    acc_we = 1'b0;
            default:    acc_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = '0;
        core_en_d = core_en_q;
        rnw_d     = rnw_q;
        bus_d     = bus_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        status_d  = status_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && ready_q) begin
                    rnw_d    = req_rnw;
                    bus_d    = req_bus;
                    addr_d   = req_addr;
                    wdata_d  = req_data;
                    rdata_d  = '0;
                    status_d = RspOk;
                    state_d  = core_en_q ? StBusDpr : StEn;
                end
            end
            StEn: begin
                if (acc_done) begin
                    core_en_d = 1'b1;
                    state_d   = StBusDpr;
                end
            end
            StBusDpr:   if (acc_done) state_d = StBusCmd;
            StBusCmd:   if (acc_done) begin state_d = StWait; phase_d = PhBus; end
            StStartCmd: if (acc_done) begin state_d = StWait; phase_d = PhStart; end
            StAddrDpr:  if (acc_done) state_d = StAddrCmd;
            StAddrCmd:  if (acc_done) begin state_d = StWait; phase_d = PhAddr; end
            StWrDpr:    if (acc_done) state_d = StWrCmd;
            StWrCmd:    if (acc_done) begin state_d = StWait; phase_d = PhWr; end
            StRdCmd:    if (acc_done) begin state_d = StWait; phase_d = PhRd; end
            StRdDpr: begin
                if (acc_done) begin
                    rdata_d = dat_i[7:0];
                    state_d = StStopCmd;
                end
            end
            StStopCmd:  if (acc_done) begin state_d = StWait; phase_d = PhStop; end
            StWait: begin
                if (irq_i) begin
                    state_d = StIrqRd;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    // Abort silently; the core is re-enabled on the next request.
                    core_en_d = 1'b0;
                    if (!(phase_q == PhStop && status_q == RspNak)) status_d = RspErr;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIrqRd: begin
                if (acc_done) begin
                    if (phase_q == PhStop) begin
                        if (st_al || st_err || st_nak || !st_don) begin
                            if (status_q != RspNak) status_d = RspErr;
                        end
                        state_d = StResp;
                    end else if (st_al) begin
                        status_d = RspAl;
                        state_d  = StResp;
                    end else if (st_err || !(st_nak || st_don)) begin
                        status_d = RspErr;
                        state_d  = StResp;
                    end else if (st_nak) begin
                        status_d = RspNak;
                        state_d  = StStopCmd;
                    end else begin
                        unique case (phase_q)
                            PhBus:   state_d = StStartCmd;
                            PhStart: state_d = StAddrDpr;
                            PhAddr:  state_d = rnw_q ? StRdCmd : StWrDpr;
                            PhWr:    state_d = StStopCmd;
                            PhRd:    state_d = StRdDpr;
                            default: state_d = StResp;
                        endcase
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are registered: launched one cycle after the state asks, dropped
    // on the edge that samples ack_i.
    always_comb begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = '0;
        dat_d = '0;
        if (cyc_q) begin
            if (!ack_i) begin
                cyc_d = 1'b1;
                we_d  = we_q;
                adr_d = adr_q;
                dat_d = dat_q;
            end
        end else if (acc_req) begin
            cyc_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
        end
        ready_d = (state_d == StIdle);
    end

    assign cyc_o      = cyc_q;
    assign stb_o      = cyc_q;
    assign we_o       = we_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign req_ready  = ready_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_status = rsp_valid ? status_q : RspOk;
    assign rsp_data   = (rsp_valid && status_q == RspOk && rnw_q) ? rdata_q : 8'h00;

endmodule
